// File: rtl/tm_ret_vc_allocator_pkg.sv
// Shared types and helpers for the return-VC allocator.
// Slave tag layout, credit default and log2 helper.
package tm_credit_pkg;

    localparam int DEFAULT_NUM_CREDITS      = 32;
    localparam int DEFAULT_ADDRESS_WIDTH    = 4;
    localparam int DEFAULT_VC_ADDRESS_WIDTH = 2;

    typedef struct packed {
        logic [DEFAULT_VC_ADDRESS_WIDTH-1:0] vc;
        logic [DEFAULT_ADDRESS_WIDTH-1:0]    dest;
    } slave_tag_t;

    function automatic int ceil_log2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/tm_ret_vc_allocator_if.sv
// Request/grant handshake between master and allocator.
// Grant is combinational in the same cycle as the request.
interface tm_ret_vc_allocator_if #(
    parameter int ADDRESS_WIDTH    = 4,
    parameter int VC_ADDRESS_WIDTH = 2
);

    logic                                    req_valid;
    logic [ADDRESS_WIDTH+VC_ADDRESS_WIDTH-1:0] req_tag;
    logic                                    req_ready;
    logic [VC_ADDRESS_WIDTH-1:0]             grant_vc;

    modport master (
        output req_valid,
        output req_tag,
        input  req_ready,
        input  grant_vc
    );

    modport slave (
        input  req_valid,
        input  req_tag,
        output req_ready,
        output grant_vc
    );

endinterface

// File: rtl/tm_ret_vc_allocator_slot.sv
// One return VC: binding, owner tag, outstanding count.
// Unbinds on the edge where the count reaches zero.
module tm_vc_credit_slot
    import tm_credit_pkg::*;
#(
    parameter int TAG_W       = 6,
    parameter int NUM_CREDITS = DEFAULT_NUM_CREDITS,
    parameter int CW          = ceil_log2(NUM_CREDITS + 1),
    parameter int VC_IDX      = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    input  logic             dec_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             bound_o,
    output logic [TAG_W-1:0] owner_o,
    output logic             full_o,
    output logic             underflow_o
);

    logic             bound_q, bound_d;
    logic [TAG_W-1:0] owner_q, owner_d;
    logic [CW-1:0]    count_q, count_d;
    logic             underflow_q, underflow_d;
    logic             dec_ok;

    assign dec_ok = dec_i && (count_q != '0);

    // Next-state: count, binding and sticky underflow
    always_comb begin
        count_d     = count_q;
        bound_d     = bound_q;
        owner_d     = owner_q;
        underflow_d = underflow_q;
        if (inc_i && !dec_ok) begin
            count_d = count_q + CW'(1);
        end else if (!inc_i && dec_ok) begin
            count_d = count_q - CW'(1);
        end
        if (inc_i && !bound_q) begin
            bound_d = 1'b1;
            owner_d = tag_i;
        end
        if (count_d == '0) begin
            bound_d = 1'b0;
            owner_d = '0;
        end
        if (dec_i && (count_q == '0)) begin
            underflow_d = 1'b1;
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bound_q     <= 1'b0;
            owner_q     <= '0;
            count_q     <= '0;
            underflow_q <= 1'b0;
        end else begin
            bound_q     <= bound_d;
            owner_q     <= owner_d;
            count_q     <= count_d;
            underflow_q <= underflow_d;
        end
    end

    assign bound_o     = bound_q;
    assign owner_o     = owner_q;
    assign full_o      = (count_q == CW'(NUM_CREDITS));
    assign underflow_o = underflow_q;

`ifndef SYNTHESIS
    // Report replies arriving on an empty VC; count must stay bounded
    always @(posedge clk) begin
        if (rst) begin
            if (dec_i && (count_q == '0)) begin
                $display("RET VC %0d UNDERFLOW", VC_IDX);
            end
            assert (count_q <= CW'(NUM_CREDITS))
            else $error("ret vc %0d count %0d above credit limit",
                        VC_IDX, count_q);
        end
    end
`endif

endmodule

// File: rtl/tm_ret_vc_allocator.sv
// Return-VC allocator: binds slave tags to VCs and
// grants same-cycle, keeping one VC per tag for ordering.
module tm_ret_vc_allocator
    import tm_credit_pkg::*;
#(
    parameter int NUM_VCS          = 4,
    parameter int NUM_CREDITS      = DEFAULT_NUM_CREDITS,
    parameter int ADDRESS_WIDTH    = 4,
    parameter int VC_ADDRESS_WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    tm_ret_vc_allocator_if.slave req,
    input  logic [NUM_VCS-1:0]   receive_valid,
    output logic [NUM_VCS-1:0]   vc_busy,
    output logic [NUM_VCS-1:0]   vc_full,
    output logic                 err_underflow
);

    localparam int TAG_W = ADDRESS_WIDTH + VC_ADDRESS_WIDTH;
    localparam int CW    = ceil_log2(NUM_CREDITS + 1);

    logic [NUM_VCS-1:0]          bound;
    logic [NUM_VCS-1:0]          full;
    logic [NUM_VCS-1:0]          uflow;
    logic [NUM_VCS-1:0]          inc;
    logic [TAG_W-1:0]            owner [NUM_VCS];

    logic                        hit;
    logic [VC_ADDRESS_WIDTH-1:0] hit_idx;
    logic                        free;
    logic [VC_ADDRESS_WIDTH-1:0] free_idx;
    logic                        ready;
    logic [VC_ADDRESS_WIDTH-1:0] grant;
    logic                        fire;

    // Lowest-index owner match and lowest-index free VC
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        free     = 1'b0;
        free_idx = '0;
        for (int i = 0; i < NUM_VCS; i++) begin
            if (!hit && bound[i] && (owner[i] == req.req_tag)) begin
                hit     = 1'b1;
                hit_idx = VC_ADDRESS_WIDTH'(i);
            end
            if (!free && !bound[i]) begin
                free     = 1'b1;
                free_idx = VC_ADDRESS_WIDTH'(i);
            end
        end
    end

    // Grant mux; a full matching VC stalls rather than opening another
    always_comb begin
        ready = 1'b0;
        grant = '0;
        if (hit) begin
            ready = !full[hit_idx];
            grant = hit_idx;
        end else if (free) begin
            ready = 1'b1;
            grant = free_idx;
        end
        if (!rst || !ready) begin
            ready = 1'b0;
            grant = '0;
        end
    end

    assign fire          = req.req_valid & ready;
    assign req.req_ready = ready;
    assign req.grant_vc  = grant;

    for (genvar g = 0; g < NUM_VCS; g++) begin : g_slot
        assign inc[g] = fire && (grant == VC_ADDRESS_WIDTH'(g));

        tm_vc_credit_slot #(
            .TAG_W       (TAG_W),
            .NUM_CREDITS (NUM_CREDITS),
            .CW          (CW),
            .VC_IDX      (g)
        ) u_slot (
            .clk         (clk),
            .rst         (rst),
            .inc_i       (inc[g]),
            .dec_i       (receive_valid[g]),
            .tag_i       (req.req_tag),
            .bound_o     (bound[g]),
            .owner_o     (owner[g]),
            .full_o      (full[g]),
            .underflow_o (uflow[g])
        );
    end

    assign vc_busy       = bound;
    assign vc_full       = full;
    assign err_underflow = |uflow;

endmodule

// File: tb/tb_tm_ret_vc_allocator.sv
// Directed bench for the return-VC allocator.
// Expected values are hand-computed per scenario.
module tb_tm_ret_vc_allocator;
    import tm_credit_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] rv;
    logic [3:0] busy;
    logic [3:0] full;
    logic       err;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    tm_ret_vc_allocator_if bus ();

    tm_ret_vc_allocator dut (
        .clk           (clk),
        .rst           (rst),
        .req           (bus),
        .receive_valid (rv),
        .vc_busy       (busy),
        .vc_full       (full),
        .err_underflow (err)
    );

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        slave_tag_t t;
        bus.req_valid = 1'b0;
        bus.req_tag   = '0;
        rv            = '0;

        #2 rst = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_tag   = 6'h05;
        #1;
        check("rst_ready", 32'(bus.req_ready), 0);
        check("rst_grant", 32'(bus.grant_vc), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_err", 32'(err), 0);
        repeat (2) tick();

        rst = 1'b1;
        #1;
        check("first_ready", 32'(bus.req_ready), 1);
        check("first_grant", 32'(bus.grant_vc), 0);
        tick();
        check("first_busy", 32'(busy), 32'h1);
        check("first_cnt", 32'(dut.g_slot[0].u_slot.count_q), 1);

        repeat (31) tick();
        check("full_cnt", 32'(dut.g_slot[0].u_slot.count_q), 32);
        check("full_ready", 32'(bus.req_ready), 0);
        check("full_flag", 32'(full), 32'h1);
        check("full_grant", 32'(bus.grant_vc), 0);

        rv = 4'b0001;
        tick();
        rv = 4'b0000;
        bus.req_valid = 1'b0;
        #1;
        check("refill_ready", 32'(bus.req_ready), 1);
        check("refill_grant", 32'(bus.grant_vc), 0);
        check("refill_full", 32'(full), 0);

        rv = 4'b0001;
        repeat (31) tick();
        rv = 4'b0000;
        check("drain_busy", 32'(busy), 0);
        check("drain_cnt", 32'(dut.g_slot[0].u_slot.count_q), 0);

        for (int k = 0; k < 4; k++) begin
            bus.req_valid = 1'b1;
            bus.req_tag   = 6'(k + 1);
            #1;
            check("multi_ready", 32'(bus.req_ready), 1);
            check("multi_grant", 32'(bus.grant_vc), 32'(k));
            tick();
        end
        check("multi_busy", 32'(busy), 32'hf);

        t.vc   = 2'd0;
        t.dest = 4'd6;
        bus.req_tag = t;
        #1;
        check("allbound_ready", 32'(bus.req_ready), 0);
        check("allbound_grant", 32'(bus.grant_vc), 0);
        bus.req_valid = 1'b0;
        rv = 4'b0100;
        tick();
        rv = 4'b0000;
        check("release_busy", 32'(busy), 32'hb);
        bus.req_valid = 1'b1;
        #1;
        check("reuse_ready", 32'(bus.req_ready), 1);
        check("reuse_grant", 32'(bus.grant_vc), 2);
        tick();
        bus.req_valid = 1'b0;
        check("reuse_busy", 32'(busy), 32'hf);

        bus.req_valid = 1'b1;
        bus.req_tag   = 6'h01;
        rv = 4'b0001;
        #1;
        check("simul_grant", 32'(bus.grant_vc), 0);
        tick();
        bus.req_valid = 1'b0;
        rv = 4'b0000;
        check("simul_cnt", 32'(dut.g_slot[0].u_slot.count_q), 1);
        check("simul_busy", 32'(busy), 32'hf);

        rv = 4'b1000;
        tick();
        check("vc3_busy", 32'(busy), 32'h7);
        check("vc3_err", 32'(err), 0);
        tick();
        rv = 4'b0000;
        check("uf_err", 32'(err), 1);
        check("uf_cnt3", 32'(dut.g_slot[3].u_slot.count_q), 0);
        check("uf_cnt0", 32'(dut.g_slot[0].u_slot.count_q), 1);
        check("uf_cnt1", 32'(dut.g_slot[1].u_slot.count_q), 1);
        check("uf_cnt2", 32'(dut.g_slot[2].u_slot.count_q), 1);
        check("uf_busy", 32'(busy), 32'h7);
        tick();
        check("uf_sticky", 32'(err), 1);

        bus.req_valid = 1'b1;
        bus.req_tag   = 6'h01;
        repeat (6) tick();
        check("burst_cnt", 32'(dut.g_slot[0].u_slot.count_q), 7);
        rst = 1'b0;
        #1;
        check("arst_ready", 32'(bus.req_ready), 0);
        check("arst_busy", 32'(busy), 0);
        check("arst_cnt", 32'(dut.g_slot[0].u_slot.count_q), 0);
        check("arst_err", 32'(err), 0);
        repeat (2) tick();
        rst = 1'b1;
        bus.req_tag = 6'h09;
        #1;
        check("post_ready", 32'(bus.req_ready), 1);
        check("post_grant", 32'(bus.grant_vc), 0);
        tick();
        bus.req_valid = 1'b0;
        check("post_busy", 32'(busy), 32'h1);
        check("post_cnt", 32'(dut.g_slot[0].u_slot.count_q), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tm_ret_vc_allocator.md
Name: tm_ret_vc_allocator

Overview:
Standalone return-VC allocator and credit scheduler for a NoC master that issues requests to multiple slaves. Each request carries a slave tag ({vc, dest}). The block binds each active slave tag to one return VC and counts outstanding requests per VC. A VC is released when all of its replies have returned. It sits between the master's request skid buffer and the packetizer, and replaces inline allocation logic in the master credit shells.

Parameters:
- NUM_VCS, 4, number of return VCs managed; power of 2, at least 2.
- NUM_CREDITS, 32, maximum outstanding requests per return VC.
- ADDRESS_WIDTH, 4, width of the destination router address.
- VC_ADDRESS_WIDTH, 2, width of the VC index; equals $clog2(NUM_VCS).

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- rst, input, 1, reset; asynchronous, active-low.
- req_valid, input, 1, the master has a request ready to issue.
- req_tag, input, ADDRESS_WIDTH+VC_ADDRESS_WIDTH, slave tag {dest_vc, dest}.
- req_ready, output, 1, the request may issue this cycle.
- grant_vc, output, VC_ADDRESS_WIDTH, return VC to attach to the request.
- receive_valid, input, NUM_VCS, one-hot-per-VC reply arrival; several bits may be set in the same cycle.
- vc_busy, output, NUM_VCS, VC is bound to a slave tag.
- vc_full, output, NUM_VCS, VC count equals NUM_CREDITS.
- err_underflow, output, 1, sticky: a reply arrived on a VC whose count was 0.

Behaviour:
- Per-VC state, registered: bound (1b), owner tag, count (width $clog2(NUM_CREDITS+1)).
- Reset (rst=0, asynchronous):
  - bound=0, owner=0, count=0, err_underflow=0.
  - req_ready=0 and grant_vc=0 while reset is asserted.
- Lookup is combinational, with the same-cycle grant path from req_valid/req_tag:
  - Match: lowest-index VC i with bound[i] and owner[i]==req_tag.
  - Match with count[i]<NUM_CREDITS: req_ready=1, grant_vc=i.
  - Match with count[i]==NUM_CREDITS: req_ready=0 (stall). Never open a second VC for the same tag; this preserves reply order.
  - No match: lowest-index VC with bound==0 gives req_ready=1, grant_vc=that index.
  - No match and every VC bound: req_ready=0.
  - req_ready is valid even when req_valid=0 (lookahead).
  - When req_ready=0, grant_vc=0.
- Fire = req_valid & req_ready. On the next edge:
  - count[grant_vc]+1.
  - For a new binding, also bound=1 and owner=req_tag.
- Release: receive_valid[i] decrements count[i] on the edge.
- Simultaneous fire and release on the same VC: count unchanged, binding kept.
- Unbind: when the next count of a bound VC is 0, set bound=0 and owner=0 on the same edge. The VC is allocatable from the following cycle.
- Underflow: receive_valid[i] with count[i]==0 leaves count at 0 and sets err_underflow=1 until reset. The simulation-only check also prints "RET VC %d UNDERFLOW"; it is excluded from synthesis.
- Overflow is impossible by construction; add a simulation-only assertion that count never exceeds NUM_CREDITS.
- vc_busy=bound and vc_full=(count==NUM_CREDITS); both are pure register decodes.
- Reset mid-operation: all bindings are lost. Replies still in flight afterwards raise err_underflow; the master must drain before asserting reset.
- Latency: grant in 0 cycles; state visible 1 cycle later.
- Throughput: 1 grant per cycle.

Decomposition:
- Package tm_credit_pkg holds:
  - slave_tag_t, a packed {vc, dest} type.
  - function ceil_log2.
  - Constant DEFAULT_NUM_CREDITS=32.
- Sub-module tm_vc_credit_slot: one VC's bound/owner/count registers, inc/dec/unbind logic and its underflow flag. It is instantiated NUM_VCS times.
- The top level holds the match/free priority encoders and the grant mux.

Test Plan:
- Post-reset (rst 0→1), req_valid=1, tag=0x05 → req_ready=1, grant_vc=0; next cycle vc_busy=4'b0001, count0=1.
- 32 back-to-back fires to tag 0x05 with no replies → 33rd cycle req_ready=0, vc_full[0]=1. One receive_valid[0] → next cycle req_ready=1, grant_vc=0.
- Tags 0x01,0x02,0x03,0x04 one fire each → grant_vc 0,1,2,3. Tag 0x06 → req_ready=0. receive_valid=4'b0100 → next cycle vc_busy=4'b1011, tag 0x06 granted vc 2.
- Count0=1 with fire to tag 0x05 and receive_valid[0] in the same cycle → count0 stays 1, vc_busy[0] stays 1.
- receive_valid=4'b1000 while count3=0 → err_underflow=1 and stays 1; all counts unchanged.
- rst pulsed low mid-burst (count0=7) → asynchronously req_ready=0, vc_busy=0, counts=0; after release, tag 0x09 granted vc 0.
